// File: rtl/spr_pkg.sv
// +--------------------------------------------------------------------+
// | spr_pkg                                                            |
// | Shared constants for the sprite attribute table and its helpers.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package spr_pkg;
    localparam int CORDW       = 16;
    localparam int VELW        = 8;
    localparam int CTRL_EN_BIT = 0;

    localparam logic [1:0] FLD_X    = 2'd0;
    localparam logic [1:0] FLD_Y    = 2'd1;
    localparam logic [1:0] FLD_CTRL = 2'd2;
    localparam logic [1:0] FLD_VEL  = 2'd3;
endpackage

`default_nettype wire

// File: rtl/spr_axis_bounce.sv
// +--------------------------------------------------------------------+
// | spr_axis_bounce                                                    |
// | One-axis position step with clamp to [0, LIMIT] and velocity flip. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spr_axis_bounce #(
    parameter int CORDW = 16,
    parameter int VELW  = 8,
    parameter int LIMIT = 576
) (
    input  logic signed [CORDW-1:0] i_pos,
    input  logic signed [VELW-1:0]  i_vel,
    output logic signed [CORDW-1:0] o_pos,
    output logic signed [VELW-1:0]  o_vel
);
    localparam logic signed [CORDW-1:0] c_limit = CORDW'(LIMIT);

    logic signed [CORDW-1:0] w_vel_ext;
    logic signed [CORDW-1:0] w_sum;

    assign w_vel_ext = {{(CORDW-VELW){i_vel[VELW-1]}}, i_vel};
    assign w_sum     = i_pos + w_vel_ext;

    always_comb begin
        o_pos = w_sum;
        o_vel = i_vel;
        if (w_sum > c_limit) begin
            o_pos = c_limit;
            o_vel = -i_vel;
        end else if (w_sum[CORDW-1]) begin
            o_pos = '0;
            o_vel = -i_vel;
        end
    end
endmodule

`default_nettype wire

// File: rtl/sprite_attr_table.sv
// +--------------------------------------------------------------------+
// | sprite_attr_table                                                  |
// | Shadow/active sprite attribute banks, atomic copy on frame pulse.  |
// | Optional per-frame bounce motion: define SPR_AUTO_MOVE_EN.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sprite_attr_table #(
    parameter int CORDW     = 16,
    parameter int NUM_SPR   = 4,
    parameter int IDXW      = 2,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int SPR_DRAWW = 64,
    parameter int SPR_DRAWH = 64
) (
    input  logic                    clk_25MHz,
    input  logic                    btn_rst_n,
    input  logic                    frame,
    input  logic                    wr_en,
    input  logic [IDXW+1:0]         wr_addr,
    input  logic [15:0]             wr_data,
    input  logic                    commit,
    output logic                    commit_pending,
    input  logic [IDXW-1:0]         rd_idx,
    output logic signed [CORDW-1:0] spr_x,
    output logic signed [CORDW-1:0] spr_y,
    output logic                    spr_en
);
    import spr_pkg::*;

    if (NUM_SPR != (1 << IDXW) || H_RES <= SPR_DRAWW || V_RES <= SPR_DRAWH) begin : g_bad_cfg
        $error("sprite_attr_table: inconsistent geometry parameters");
    end

    logic signed [CORDW-1:0] r_sh_x  [NUM_SPR];
    logic signed [CORDW-1:0] r_sh_y  [NUM_SPR];
    logic                    r_sh_en [NUM_SPR];
    logic signed [CORDW-1:0] r_act_x  [NUM_SPR];
    logic signed [CORDW-1:0] r_act_y  [NUM_SPR];
    logic                    r_act_en [NUM_SPR];
    logic                    r_commit_pending;

    logic [IDXW-1:0] w_wr_idx;
    logic [1:0]      w_wr_fld;
    logic            w_copy;

    assign w_wr_idx       = wr_addr[IDXW+1:2];
    assign w_wr_fld       = wr_addr[1:0];
    assign w_copy         = frame & (r_commit_pending | commit);
    assign commit_pending = r_commit_pending;

`ifdef SPR_AUTO_MOVE_EN
    logic signed [VELW-1:0]  r_sh_vx  [NUM_SPR];
    logic signed [VELW-1:0]  r_sh_vy  [NUM_SPR];
    logic signed [VELW-1:0]  r_act_vx [NUM_SPR];
    logic signed [VELW-1:0]  r_act_vy [NUM_SPR];
    logic signed [CORDW-1:0] w_nx_x   [NUM_SPR];
    logic signed [CORDW-1:0] w_nx_y   [NUM_SPR];
    logic signed [VELW-1:0]  w_nx_vx  [NUM_SPR];
    logic signed [VELW-1:0]  w_nx_vy  [NUM_SPR];

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
        spr_axis_bounce #(.CORDW(CORDW), .VELW(VELW), .LIMIT(H_RES - SPR_DRAWW)) u_bx (
            .i_pos(r_act_x[g]), .i_vel(r_act_vx[g]), .o_pos(w_nx_x[g]), .o_vel(w_nx_vx[g])
        );
        spr_axis_bounce #(.CORDW(CORDW), .VELW(VELW), .LIMIT(V_RES - SPR_DRAWH)) u_by (
            .i_pos(r_act_y[g]), .i_vel(r_act_vy[g]), .o_pos(w_nx_y[g]), .o_vel(w_nx_vy[g])
        );
    end
`endif

    // Shadow bank: written freely; the copy reads the pre-write contents.
    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                r_sh_x[i]  <= '0;
                r_sh_y[i]  <= '0;
                r_sh_en[i] <= 1'b0;
`ifdef SPR_AUTO_MOVE_EN
                r_sh_vx[i] <= '0;
                r_sh_vy[i] <= '0;
`endif
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                if (w_wr_idx == IDXW'(i)) begin
                    case (w_wr_fld)
                        FLD_X:    r_sh_x[i]  <= wr_data[CORDW-1:0];
                        FLD_Y:    r_sh_y[i]  <= wr_data[CORDW-1:0];
                        FLD_CTRL: r_sh_en[i] <= wr_data[CTRL_EN_BIT];
`ifdef SPR_AUTO_MOVE_EN
                        FLD_VEL: begin
                            r_sh_vx[i] <= wr_data[VELW-1:0];
                            r_sh_vy[i] <= wr_data[2*VELW-1:VELW];
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            r_commit_pending <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                r_act_x[i]  <= '0;
                r_act_y[i]  <= '0;
                r_act_en[i] <= 1'b0;
`ifdef SPR_AUTO_MOVE_EN
                r_act_vx[i] <= '0;
                r_act_vy[i] <= '0;
`endif
            end
        end else begin
            if (w_copy)
                r_commit_pending <= 1'b0;
            else if (commit)
                r_commit_pending <= 1'b1;

            for (int i = 0; i < NUM_SPR; i++) begin
                if (w_copy) begin
                    r_act_x[i]  <= r_sh_x[i];
                    r_act_y[i]  <= r_sh_y[i];
                    r_act_en[i] <= r_sh_en[i];
`ifdef SPR_AUTO_MOVE_EN
                    r_act_vx[i] <= r_sh_vx[i];
                    r_act_vy[i] <= r_sh_vy[i];
                end else if (frame && r_act_en[i]) begin
                    r_act_x[i]  <= w_nx_x[i];
                    r_act_y[i]  <= w_nx_y[i];
                    r_act_vx[i] <= w_nx_vx[i];
                    r_act_vy[i] <= w_nx_vy[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            spr_x  <= '0;
            spr_y  <= '0;
            spr_en <= 1'b0;
        end else begin
            spr_x  <= r_act_x[rd_idx];
            spr_y  <= r_act_y[rd_idx];
            spr_en <= r_act_en[rd_idx];
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_sprite_attr_table.sv
// +--------------------------------------------------------------------+
// | tb_sprite_attr_table                                               |
// | Directed scoreboard bench for sprite_attr_table.                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sprite_attr_table;
    import spr_pkg::*;

    typedef struct {
        logic [1:0]         idx;
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic               en;
        logic               pend;
    } exp_t;

    logic               clk = 1'b0;
    logic               btn_rst_n = 1'b0;
    logic               frame = 1'b0;
    logic               wr_en = 1'b0;
    logic [3:0]         wr_addr = '0;
    logic [15:0]        wr_data = '0;
    logic               commit = 1'b0;
    logic               commit_pending;
    logic [1:0]         rd_idx = '0;
    logic signed [15:0] spr_x;
    logic signed [15:0] spr_y;
    logic               spr_en;

    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sprite_attr_table dut (
        .clk_25MHz      (clk),
        .btn_rst_n      (btn_rst_n),
        .frame          (frame),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .rd_idx         (rd_idx),
        .spr_x          (spr_x),
        .spr_y          (spr_y),
        .spr_en         (spr_en)
    );

    always #20 clk = ~clk;

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: each tagged read is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_read: no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks += 4;
                if (spr_x !== e.x) begin
                    errors++;
                    $display("FAIL spr_x[%0d]: got %0d expected %0d", e.idx, spr_x, e.x);
                end
                if (spr_y !== e.y) begin
                    errors++;
                    $display("FAIL spr_y[%0d]: got %0d expected %0d", e.idx, spr_y, e.y);
                end
                if (spr_en !== e.en) begin
                    errors++;
                    $display("FAIL spr_en[%0d]: got %b expected %b", e.idx, spr_en, e.en);
                end
                if (commit_pending !== e.pend) begin
                    errors++;
                    $display("FAIL commit_pending(rd %0d): got %b expected %b", e.idx, commit_pending, e.pend);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] idx, input logic [1:0] fld, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = {idx, fld}; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic rd(input logic [1:0] idx, input int x, input int y, input logic en, input logic pend);
        exp_t e;
        e.idx = idx; e.x = 16'(x); e.y = 16'(y); e.en = en; e.pend = pend;
        exp_q.push_back(e);
        rd_idx = idx; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        btn_rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) rd(2'(i), 0, 0, 1'b0, 1'b0);

        // Shadow writes without commit stay invisible.
        wr(2'd1, FLD_X, 16'd100);
        wr(2'd1, FLD_Y, 16'd25);
        wr(2'd1, FLD_CTRL, 16'h0001);
        pulse_frame();
        rd(2'd1, 0, 0, 1'b0, 1'b0);

        pulse_commit();
        rd(2'd1, 0, 0, 1'b0, 1'b1);
        pulse_frame();
        rd(2'd1, 100, 25, 1'b1, 1'b0);

        // commit + frame + write together: copy sees the old shadow x.
        commit = 1'b1; frame = 1'b1;
        wr(2'd1, FLD_X, 16'd200);
        commit = 1'b0; frame = 1'b0;
        rd(2'd1, 100, 25, 1'b1, 1'b0);
        pulse_commit();
        pulse_frame();
        rd(2'd1, 200, 25, 1'b1, 1'b0);

        // A velocity write alone never moves the active bank.
        wr(2'd1, FLD_VEL, 16'h0303);
        pulse_frame();
        rd(2'd1, 200, 25, 1'b1, 1'b0);

        // Reset with a commit pending drops it; frames during reset do nothing.
        pulse_commit();
        rd(2'd1, 200, 25, 1'b1, 1'b1);
        btn_rst_n = 1'b0; frame = 1'b1;
        repeat (2) @(negedge clk);
        frame = 1'b0; btn_rst_n = 1'b1;
        @(negedge clk);
        rd(2'd1, 0, 0, 1'b0, 1'b0);
        wr(2'd1, FLD_X, 16'd300);
        wr(2'd1, FLD_CTRL, 16'h0001);
        pulse_frame();
        rd(2'd1, 0, 0, 1'b0, 1'b0);

`ifdef SPR_AUTO_MOVE_EN
        wr(2'd0, FLD_X, 16'd570);
        wr(2'd0, FLD_VEL, 16'h0004);
        wr(2'd0, FLD_CTRL, 16'h0001);
        pulse_commit();
        pulse_frame();
        rd(2'd0, 570, 0, 1'b1, 1'b0);
        pulse_frame();
        rd(2'd0, 574, 0, 1'b1, 1'b0);
        pulse_frame();
        rd(2'd0, 576, 0, 1'b1, 1'b0);
        pulse_frame();
        rd(2'd0, 572, 0, 1'b1, 1'b0);

        wr(2'd0, FLD_X, 16'd2);
        wr(2'd0, FLD_VEL, 16'h00FC);
        pulse_commit();
        pulse_frame();
        rd(2'd0, 2, 0, 1'b1, 1'b0);
        pulse_frame();
        rd(2'd0, 0, 0, 1'b1, 1'b0);
        pulse_frame();
        rd(2'd0, 4, 0, 1'b1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: %0d expectations never compared, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
